// File: rtl/corr_peak_detector.sv
// corr_peak_detector: per-frame |x|^2 peak search over a complex AXI-Stream, one result beat per frame.
//   aclk, aresetn            clock, asynchronous active-low reset
//   S_AXIS_DATA_*            input samples {im, re}, signed, tlast marks frame end
//   M_AXIS_PEAK_*            result: [32:0] peak_mag, [42:33] peak_idx, [43] len_err, [44] detect
//   optional (CORR_THRESH_EN): peak_thresh in, detect_pulse out
module corr_peak_detector #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 1024,
  parameter int IDX_W     = 10
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [2*DATA_W-1:0]   S_AXIS_DATA_tdata,
  input  logic                  S_AXIS_DATA_tvalid,
  input  logic                  S_AXIS_DATA_tlast,
  output logic                  S_AXIS_DATA_tready,
  output logic [63:0]           M_AXIS_PEAK_tdata,
  output logic                  M_AXIS_PEAK_tvalid,
  input  logic                  M_AXIS_PEAK_tready
`ifdef CORR_THRESH_EN
  ,
  input  logic [32:0]           peak_thresh,
  output logic                  detect_pulse
`endif
);
  localparam int PW = 2 * DATA_W;
  localparam int MW = PW + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  typedef enum logic [1:0] {ACCUM, DRAIN, REPORT} state_t;
  state_t              state_q, state_d;
  logic                rdy_q;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                len_err_q, len_err_d;
  logic [1:0]          drain_q, drain_d;
  logic                s1_valid_q, s1_valid_d, s1_first_q, s1_first_d;
  logic [PW-1:0]       s1_re2_q, s1_re2_d, s1_im2_q, s1_im2_d;
  logic [IDX_W-1:0]    s1_idx_q, s1_idx_d;
  logic                s2_valid_q, s2_valid_d, s2_first_q, s2_first_d;
  logic [MW-1:0]       s2_mag_q, s2_mag_d;
  logic [IDX_W-1:0]    s2_idx_q, s2_idx_d;
  logic [MW-1:0]       max_q, max_d;
  logic [IDX_W-1:0]    max_idx_q, max_idx_d;
  logic                m_valid_q, m_valid_d;
  logic [63:0]         m_data_q, m_data_d;
  logic signed [DATA_W-1:0] re, im;
  logic                acc, at_end, hs, det;
  assign re = S_AXIS_DATA_tdata[DATA_W-1:0];
  assign im = S_AXIS_DATA_tdata[2*DATA_W-1:DATA_W];
  // rdy_q holds tready low until the first edge after reset release
  assign S_AXIS_DATA_tready = rdy_q && (state_q == ACCUM);
  assign M_AXIS_PEAK_tvalid = m_valid_q;
  assign M_AXIS_PEAK_tdata  = m_data_q;
  assign acc    = S_AXIS_DATA_tvalid && S_AXIS_DATA_tready;
  assign at_end = cnt_q == LAST_IDX;
  assign hs     = m_valid_q && M_AXIS_PEAK_tready;
`ifdef CORR_THRESH_EN
  assign det          = max_q >= peak_thresh;
  assign detect_pulse = hs && m_data_q[44];
`else
  assign det = 1'b0;
`endif
  always_comb begin
    s1_valid_d = acc;
    s1_first_d = cnt_q == '0;
    s1_idx_d   = cnt_q;
    s1_re2_d   = re * re;
    s1_im2_d   = im * im;
    s2_valid_d = s1_valid_q;
    s2_first_d = s1_first_q;
    s2_idx_d   = s1_idx_q;
    // both products are non-negative, so zero-extension keeps the 33-bit sum exact
    s2_mag_d   = MW'(s1_re2_q) + MW'(s1_im2_q);
    max_d      = max_q;
    max_idx_d  = max_idx_q;
    if (state_q == REPORT && hs) begin
      max_d     = '0;
      max_idx_d = '0;
    end else if (s2_valid_q && (s2_first_q || s2_mag_q > max_q)) begin
      max_d     = s2_mag_q;
      max_idx_d = s2_idx_q;
    end
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
    drain_d   = drain_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    unique case (state_q)
      ACCUM: if (acc) begin
        cnt_d = at_end ? cnt_q : cnt_q + 1'b1;
        if (S_AXIS_DATA_tlast || at_end) begin
          state_d   = DRAIN;
          drain_d   = '0;
          // early tlast, or a full frame without tlast
          len_err_d = len_err_q | (S_AXIS_DATA_tlast ^ at_end);
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        // the last sample's compare lands the edge before this one
        if (drain_q == 2'd2) begin
          state_d   = REPORT;
          m_valid_d = 1'b1;
          m_data_d  = 64'({det, len_err_q, 10'(max_idx_q), max_q});
        end
      end
      REPORT: if (hs) begin
        state_d   = ACCUM;
        cnt_d     = '0;
        len_err_d = 1'b0;
        m_valid_d = 1'b0;
        m_data_d  = '0;
      end
      default: state_d = ACCUM;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q    <= ACCUM;
      rdy_q      <= 1'b0;
      cnt_q      <= '0;
      len_err_q  <= 1'b0;
      drain_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_re2_q   <= '0;
      s1_im2_q   <= '0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_mag_q   <= '0;
      s2_idx_q   <= '0;
      max_q      <= '0;
      max_idx_q  <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= 1'b1;
      cnt_q      <= cnt_d;
      len_err_q  <= len_err_d;
      drain_q    <= drain_d;
      s1_valid_q <= s1_valid_d;
      s1_first_q <= s1_first_d;
      s1_re2_q   <= s1_re2_d;
      s1_im2_q   <= s1_im2_d;
      s1_idx_q   <= s1_idx_d;
      s2_valid_q <= s2_valid_d;
      s2_first_q <= s2_first_d;
      s2_mag_q   <= s2_mag_d;
      s2_idx_q   <= s2_idx_d;
      max_q      <= max_d;
      max_idx_q  <= max_idx_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
    end
endmodule

// File: tb/tb_corr_peak_detector.sv
// tb_corr_peak_detector: directed frames with hand-computed peak results for corr_peak_detector.
module tb_corr_peak_detector;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem [1024];
`ifdef CORR_THRESH_EN
  logic [32:0] peak_thresh = 33'd999999;
  logic        detect_pulse;
  int          pulses = 0;
  always @(posedge clk) if (detect_pulse) pulses++;
`endif
  always #5 clk = ~clk;
  corr_peak_detector dut (
    .aclk(clk),
    .aresetn(rst_n),
    .S_AXIS_DATA_tdata(s_tdata),
    .S_AXIS_DATA_tvalid(s_tvalid),
    .S_AXIS_DATA_tlast(s_tlast),
    .S_AXIS_DATA_tready(s_tready),
    .M_AXIS_PEAK_tdata(m_tdata),
    .M_AXIS_PEAK_tvalid(m_tvalid),
    .M_AXIS_PEAK_tready(m_tready)
`ifdef CORR_THRESH_EN
    ,
    .peak_thresh(peak_thresh),
    .detect_pulse(detect_pulse)
`endif
  );
  function automatic logic [63:0] exp_word(input logic [32:0] mag, input int idx, input bit err);
    bit d = 1'b0;
`ifdef CORR_THRESH_EN
    d = mag >= 33'd999999;
`endif
    return {19'd0, d, err, idx[9:0], mag};
  endfunction
  task automatic clear_mem();
    foreach (mem[i]) mem[i] = '0;
  endtask
  task automatic send(input int n, input bit lst);
    bit bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_tdata  = mem[i];
      s_tvalid = 1'b1;
      s_tlast  = lst && (i == n - 1);
      if (s_tready !== 1'b1) bad = 1'b1;
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL send_tready: tready low during %0d-beat frame, required 1", n);
    end
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    while (m_tvalid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (m_tvalid !== 1'b1) lat = -1;
  endtask
  task automatic handshake();
    @(negedge clk);
    m_tready = 1'b1;
    @(negedge clk);
    m_tready = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (s_tready !== 1'b0) begin failures++; $display("FAIL reset_s_tready: got %b, required 0", s_tready); end
    checks++;
    if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid: got %b, required 0", m_tvalid); end
    checks++;
    if (m_tdata !== 64'd0) begin failures++; $display("FAIL reset_m_tdata: got %h, required 0", m_tdata); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1) begin failures++; $display("FAIL reset_release_tready: got %b, required 1", s_tready); end
  endtask
  task automatic test_impulse();
    int lat;
    clear_mem();
    mem[511] = 32'h0000_03E8;
    send(1024, 1'b1);
    wait_valid(lat);
    checks++;
    if (lat != 3) begin failures++; $display("FAIL impulse_latency: got %0d cycles, required 3", lat); end
    checks++;
    if (m_tdata !== exp_word(33'd1000000, 511, 1'b0)) begin
      failures++; $display("FAIL impulse_data: got %h, required %h", m_tdata, exp_word(33'd1000000, 511, 1'b0));
    end
    checks++;
    if (s_tready !== 1'b0) begin failures++; $display("FAIL impulse_report_tready: got %b, required 0", s_tready); end
`ifdef CORR_THRESH_EN
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL detect_pulse_early: got %0d pulses, required 0", pulses); end
`endif
    handshake();
    checks++;
    if (m_tvalid !== 1'b0) begin failures++; $display("FAIL impulse_tvalid_drop: got %b, required 0", m_tvalid); end
`ifdef CORR_THRESH_EN
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL detect_pulse: got %0d pulses, required 1", pulses); end
`endif
  endtask
  task automatic test_tie();
    int lat;
    clear_mem();
    mem[5]   = {16'hFED4, 16'h00C8};
    mem[900] = {16'hFED4, 16'h00C8};
    send(1024, 1'b1);
    wait_valid(lat);
    checks++;
    if (m_tdata !== exp_word(33'd130000, 5, 1'b0)) begin
      failures++; $display("FAIL tie_data: got %h, required %h (lat %0d)", m_tdata, exp_word(33'd130000, 5, 1'b0), lat);
    end
    handshake();
  endtask
  task automatic test_extremes();
    int lat;
    clear_mem();
    mem[77] = 32'h8000_8000;
    send(1024, 1'b1);
    wait_valid(lat);
    checks++;
    if (m_tdata !== exp_word(33'h1_0000_0000 >> 1, 77, 1'b0)) begin
      failures++; $display("FAIL extremes_data: got %h, required %h (lat %0d)", m_tdata, exp_word(33'd2147483648, 77, 1'b0), lat);
    end
    handshake();
  endtask
  task automatic test_backpressure();
    int lat;
    bit bad = 1'b0;
    logic [63:0] want;
    clear_mem();
    mem[511] = 32'h0000_03E8;
    want = exp_word(33'd1000000, 511, 1'b0);
    send(1024, 1'b1);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = 32'h7FFF_7FFF;
      if (m_tvalid !== 1'b1 || m_tdata !== want || s_tready !== 1'b0) bad = 1'b1;
    end
    s_tvalid = 1'b0;
    checks++;
    if (bad || lat != 3) begin
      failures++; $display("FAIL backpressure_hold: tdata %h tvalid %b s_tready %b, required %h 1 0", m_tdata, m_tvalid, s_tready, want);
    end
    handshake();
    clear_mem();
    mem[5]   = {16'hFED4, 16'h00C8};
    mem[900] = {16'hFED4, 16'h00C8};
    send(1024, 1'b1);
    wait_valid(lat);
    checks++;
    if (m_tdata !== exp_word(33'd130000, 5, 1'b0)) begin
      failures++; $display("FAIL backpressure_second: got %h, required %h", m_tdata, exp_word(33'd130000, 5, 1'b0));
    end
    handshake();
  endtask
  task automatic test_len_short();
    int lat;
    clear_mem();
    mem[50]  = {16'd4, 16'd3};
    mem[200] = {16'd1000, 16'd1000};
    send(100, 1'b1);
    wait_valid(lat);
    checks++;
    if (m_tdata !== exp_word(33'd25, 50, 1'b1)) begin
      failures++; $display("FAIL len_short: got %h, required %h (lat %0d)", m_tdata, exp_word(33'd25, 50, 1'b1), lat);
    end
    handshake();
  endtask
  task automatic test_no_tlast();
    int lat;
    clear_mem();
    mem[1000] = {16'd0, 16'd10};
    send(1024, 1'b0);
    wait_valid(lat);
    checks++;
    if (m_tdata !== exp_word(33'd100, 1000, 1'b1) || lat != 3) begin
      failures++; $display("FAIL no_tlast: got %h lat %0d, required %h lat 3", m_tdata, lat, exp_word(33'd100, 1000, 1'b1));
    end
    handshake();
  endtask
  task automatic test_reset_mid();
    int lat;
    bit seen = 1'b0;
    clear_mem();
    mem[10] = {16'd500, 16'd500};
    send(400, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_tready !== 1'b0) begin failures++; $display("FAIL reset_mid_tready: got %b, required 0", s_tready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m_tvalid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL reset_mid_no_result: got a result, required none"); end
    clear_mem();
    mem[3] = {16'd0, 16'd7};
    send(1024, 1'b1);
    wait_valid(lat);
    checks++;
    if (m_tdata !== exp_word(33'd49, 3, 1'b0)) begin
      failures++; $display("FAIL reset_mid_next: got %h, required %h (lat %0d)", m_tdata, exp_word(33'd49, 3, 1'b0), lat);
    end
    handshake();
  endtask
  initial begin
    test_reset();
    test_impulse();
    test_tie();
    test_extremes();
    test_backpressure();
    test_len_short();
    test_no_tlast();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
